// File: rtl/temp_sample_filter.sv
// Temperature sample conditioner: outlier gate, power-of-two moving average and
// sensor-silence detection feeding the controller's current_temp input.
module temp_sample_filter #(
  parameter int AVG_LOG2     = 2,
  parameter int SPIKE_LIMIT  = 8,
  parameter int REJECT_MAX   = 3,
  parameter int STALE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  output logic [7:0] current_temp,
  output logic       temp_valid,
  output logic       sample_rejected,
  output logic       sensor_stale
);

  // state | meaning
  // FILL  | window not yet full, every sample stored unchecked
  // RUN   | window full, samples pass through the outlier gate

  localparam int W  = 1 << AVG_LOG2;
  localparam int SW = 8 + AVG_LOG2;
  localparam int PW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int RW = (REJECT_MAX > 1) ? $clog2(REJECT_MAX) : 1;
  localparam int TW = $clog2(STALE_CYCLES + 1);

  typedef enum logic {FILL, RUN} state_t;

  state_t          state_q, state_d;
  logic [7:0]      sample_buf [W];
  logic [SW-1:0]   sum;
  logic [PW-1:0]   wp;
  logic [PW-1:0]   fill_cnt;
  logic [RW-1:0]   rej_cnt;
  logic [TW-1:0]   idle_left;
  logic [8:0]      diff;
  logic            outlier;
  logic            do_write, do_flush, do_discard;

  always_comb begin
    state_d    = state_q;
    do_write   = 1'b0;
    do_flush   = 1'b0;
    do_discard = 1'b0;
    if (sample_in >= current_temp) diff = {1'b0, sample_in} - {1'b0, current_temp};
    else                           diff = {1'b0, current_temp} - {1'b0, sample_in};
    outlier = (diff > 9'(SPIKE_LIMIT));
    if (sample_valid) begin
      case (state_q)
        FILL: begin
          do_write = 1'b1;
          if (fill_cnt == PW'(W - 1)) state_d = RUN;
        end
        RUN: begin
          if (!outlier)                            do_write   = 1'b1;
          else if (rej_cnt == RW'(REJECT_MAX - 1)) do_flush   = 1'b1;
          else                                     do_discard = 1'b1;
        end
        default: state_d = FILL;
      endcase
    end
  end

  // idle_left counts down from STALE_CYCLES; terminal count means stale
  assign sensor_stale = (idle_left == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= FILL;
      sum             <= '0;
      wp              <= '0;
      fill_cnt        <= '0;
      rej_cnt         <= '0;
      idle_left       <= TW'(STALE_CYCLES);
      current_temp    <= '0;
      temp_valid      <= 1'b0;
      sample_rejected <= 1'b0;
      for (int i = 0; i < W; i++) sample_buf[i] <= '0;
    end else begin
      state_q         <= state_d;
      sample_rejected <= do_discard;

      if (do_write) begin
        sample_buf[wp] <= sample_in;
        sum            <= sum - SW'(sample_buf[wp]) + SW'(sample_in);
        wp             <= (wp == PW'(W - 1)) ? '0 : wp + 1'b1;
        rej_cnt        <= '0;
        if (state_q == FILL) fill_cnt <= fill_cnt + 1'b1;
      end else if (do_flush) begin
        // persistent outliers mean a genuine step: snap the whole window to it
        for (int i = 0; i < W; i++) sample_buf[i] <= sample_in;
        sum     <= SW'(sample_in) << AVG_LOG2;
        rej_cnt <= '0;
      end else if (do_discard) begin
        rej_cnt <= rej_cnt + 1'b1;
      end

      if (sample_valid)          idle_left <= TW'(STALE_CYCLES);
      else if (idle_left != '0)  idle_left <= idle_left - 1'b1;

      if (!sensor_stale) begin
        current_temp <= (state_q == RUN) ? 8'(sum >> AVG_LOG2) : 8'd0;
        temp_valid   <= (state_q == RUN);
      end
    end
  end

endmodule

// File: tb/tb_temp_sample_filter.sv
// Scenario bench for temp_sample_filter: expected outputs are queued as each
// sample is driven and compared when the filtered result appears.
module tb_temp_sample_filter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic [7:0] current_temp;
  logic       temp_valid;
  logic       sample_rejected;
  logic       sensor_stale;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] temp;
    logic       valid;
    logic       rej;
  } exp_t;

  exp_t sb[$];

  temp_sample_filter #(
    .AVG_LOG2(2), .SPIKE_LIMIT(8), .REJECT_MAX(3), .STALE_CYCLES(20)
  ) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .current_temp(current_temp), .temp_valid(temp_valid),
    .sample_rejected(sample_rejected), .sensor_stale(sensor_stale)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got t=%0t want finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; sample_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // drive one sample; check rejected pulse after capture edge, output one edge later
  task automatic send(input logic [7:0] v, input logic [7:0] et, input logic ev, input logic er);
    exp_t e;
    e.temp = et; e.valid = ev; e.rej = er;
    sb.push_back(e);
    @(negedge clk);
    sample_in = v; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    e = sb.pop_front();
    checks++;
    if (sample_rejected !== e.rej) begin
      errors++;
      $display("FAIL rejected sample=%0d got %b want %b", v, sample_rejected, e.rej);
    end
    @(negedge clk);
    checks++;
    if (current_temp !== e.temp) begin
      errors++;
      $display("FAIL current_temp sample=%0d got %0d want %0d", v, current_temp, e.temp);
    end
    checks++;
    if (temp_valid !== e.valid) begin
      errors++;
      $display("FAIL temp_valid sample=%0d got %b want %b", v, temp_valid, e.valid);
    end
    checks++;
    if (sample_rejected !== 1'b0) begin
      errors++;
      $display("FAIL rejected_width sample=%0d got %b want 0", v, sample_rejected);
    end
    @(negedge clk);
  endtask

  task automatic fill4(input logic [7:0] v);
    send(v, 8'd0, 1'b0, 1'b0);
    send(v, 8'd0, 1'b0, 1'b0);
    send(v, 8'd0, 1'b0, 1'b0);
    send(v, v, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (current_temp !== 8'd0 || temp_valid !== 1'b0 || sample_rejected !== 1'b0 || sensor_stale !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got temp=%0d valid=%b rej=%b stale=%b want 0 0 0 0",
               current_temp, temp_valid, sample_rejected, sensor_stale);
    end
  endtask

  task automatic test_fill();
    do_reset();
    send(8'd60, 8'd0, 1'b0, 1'b0);
    send(8'd62, 8'd0, 1'b0, 1'b0);
    send(8'd64, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    sample_in = 8'd66; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    checks++;
    if (temp_valid !== 1'b0) begin
      errors++;
      $display("FAIL fill_early_valid got %b want 0", temp_valid);
    end
    @(negedge clk);
    checks++;
    if (current_temp !== 8'd63 || temp_valid !== 1'b1) begin
      errors++;
      $display("FAIL fill_done got temp=%0d valid=%b want 63 1", current_temp, temp_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_running_avg();
    send(8'd70, 8'd65, 1'b1, 1'b0);
  endtask

  task automatic test_spike();
    do_reset();
    fill4(8'd70);
    send(8'd79, 8'd70, 1'b1, 1'b1);
    send(8'd78, 8'd72, 1'b1, 1'b0);
  endtask

  task automatic test_step_flush();
    do_reset();
    fill4(8'd70);
    send(8'd95, 8'd70, 1'b1, 1'b1);
    send(8'd95, 8'd70, 1'b1, 1'b1);
    send(8'd95, 8'd95, 1'b1, 1'b0);
    send(8'd95, 8'd95, 1'b1, 1'b0);
  endtask

  task automatic test_stale();
    do_reset();
    send(8'd70, 8'd0, 1'b0, 1'b0);
    send(8'd70, 8'd0, 1'b0, 1'b0);
    send(8'd70, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    sample_in = 8'd70; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      checks++;
      if (sensor_stale !== (k >= 20)) begin
        errors++;
        $display("FAIL stale idle=%0d got %b want %b", k, sensor_stale, (k >= 20));
      end
    end
    checks++;
    if (current_temp !== 8'd70 || temp_valid !== 1'b1) begin
      errors++;
      $display("FAIL stale_hold got temp=%0d valid=%b want 70 1", current_temp, temp_valid);
    end
    send(8'd71, 8'd70, 1'b1, 1'b0);
    checks++;
    if (sensor_stale !== 1'b0) begin
      errors++;
      $display("FAIL stale_clear got %b want 0", sensor_stale);
    end
  endtask

  task automatic test_midrun_reset();
    do_reset();
    fill4(8'd70);
    @(negedge clk);
    reset = 1'b1; sample_in = 8'd90; sample_valid = 1'b1;
    @(negedge clk);
    reset = 1'b0; sample_valid = 1'b0;
    checks++;
    if (current_temp !== 8'd0 || temp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset got temp=%0d valid=%b want 0 0", current_temp, temp_valid);
    end
    send(8'd50, 8'd0, 1'b0, 1'b0);
    send(8'd50, 8'd0, 1'b0, 1'b0);
    send(8'd50, 8'd0, 1'b0, 1'b0);
    send(8'd50, 8'd50, 1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    sample_in = 8'd0;
    sample_valid = 1'b0;
    test_reset();
    test_fill();
    test_running_avg();
    test_spike();
    test_step_flush();
    test_stale();
    test_midrun_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/temp_sample_filter.md
# temp_sample_filter

Upstream conditioning stage for `auto_temp_controller`. Accepts raw 8-bit temperature samples from the sensor interface and removes single-sample spikes with an outlier gate. Smooths the accepted samples with a power-of-two moving-average window. Drives the filtered value onto the controller's `current_temp` input and flags a silent sensor.

## Interface

Parameters:
- `AVG_LOG2`, default 2: log2 of averaging window; window `W = 2**AVG_LOG2` samples.
- `SPIKE_LIMIT`, default 8: maximum accepted |sample − current_temp|; larger is an outlier.
- `REJECT_MAX`, default 3: consecutive outliers that force a flush to the new level.
- `STALE_CYCLES`, default 1000: idle cycles without `sample_valid` before `sensor_stale` asserts.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `sample_in` in 8: raw temperature sample, unsigned.
- `sample_valid` in 1: `sample_in` valid this cycle; no backpressure, every valid sample is consumed.
- `current_temp` out 8: filtered temperature, registered.
- `temp_valid` out 1: `current_temp` is meaningful (window filled).
- `sample_rejected` out 1: one-cycle pulse, last sample discarded as outlier.
- `sensor_stale` out 1: no sample for `STALE_CYCLES` cycles.

## Operation

Storage:
- Circular buffer of W 8-bit entries, write pointer mod W, wraps silently.
- Running sum of width 8+AVG_LOG2: `sum ← sum − buf[wp] + sample`. It cannot overflow.
- `current_temp = sum >> AVG_LOG2`, truncated.

States:
- FILL (after reset):
  - Every valid sample is written with no outlier check. The fill counter increments.
  - On the W-th sample, go to RUN.
  - `current_temp` stays 0 and `temp_valid` stays 0 until the W-th sample propagates.
- RUN:
  - Outlier test: `diff = |sample_in − current_temp|`, 9-bit.
  - `diff ≤ SPIKE_LIMIT`: accept. Write the buffer, update the sum, clear the reject count.
  - `diff > SPIKE_LIMIT` and reject count < REJECT_MAX−1: discard. Buffer and sum are unchanged. Increment the reject count and pulse `sample_rejected`.
  - `diff > SPIKE_LIMIT` and reject count = REJECT_MAX−1: flush. All W entries ← sample, `sum ← sample << AVG_LOG2`, reject count ← 0. No `sample_rejected` pulse. This tracks genuine step changes.
  - Any accepted sample clears the reject count, so a non-consecutive outlier starts a new run.

Stale detection:
- A saturating counter increments each cycle with `sample_valid = 0` and clears on `sample_valid = 1`.
- `sensor_stale` is 1 whenever counter ≥ STALE_CYCLES.
- While stale, `current_temp` and `temp_valid` hold their last values.

Reset:
- Synchronous. It clears the buffer, sum, pointers, fill/reject/stale counters and all outputs, and enters FILL.
- Applies mid-operation identically.
- `sample_valid` in a reset cycle is ignored.

## Timing

- Sample captured at edge E. Buffer, sum and reject count update at E. `sample_rejected` is high for the cycle following E.
- `current_temp` and `temp_valid` update at E+1: 2-edge latency from sample to output.
- Outlier comparison at E uses `current_temp` as registered before E. For back-to-back samples, the comparison therefore sees the value from two samples earlier.
- Stale: with the last valid sample at edge E, `sensor_stale` reads 1 after edge E+STALE_CYCLES. A valid sample at edge F clears it after F.
- Reset values: `current_temp = 0`, `temp_valid = 0`, `sample_rejected = 0`, `sensor_stale = 0`.

## Test plan

Defaults unless stated; `STALE_CYCLES = 20` for the bench. Samples are spaced ≥ 3 cycles apart unless stated.

- **Fill:** reset, then samples 60, 62, 64, 66. Required: `temp_valid = 0` until 2 edges after the 4th capture, then `current_temp = 63` and `temp_valid = 1`.
- **Running average:** continue with sample 70, which replaces 60. Required: `current_temp = 65` (262 >> 2).
- **Spike gate:** fill with four 70s, then send 79 (diff 9). Required: `sample_rejected` pulses once and `current_temp` stays 70. Then send 78 (diff 8). Required: accepted, `current_temp = 72`.
- **Step flush:** fill with four 70s, then send three 95s. Required: the first two pulse `sample_rejected` with output 70. The third flushes, giving `current_temp = 95` with no pulse. A subsequent 95 is accepted and the output stays 95.
- **Stale:** stop samples after fill. Required: `sensor_stale` is 0 through 19 idle cycles and 1 from the 20th onward, with `current_temp` held. The next sample clears the flag.
- **Mid-run reset:** reset for one cycle, with `sample_valid = 1` carrying 90, while `current_temp = 70`. Required: after the reset edge, `current_temp = 0` and `temp_valid = 0`, and the 90 is not stored. Four new samples are required before `temp_valid` returns to 1.
